// File: rtl/fifox_rd_merger_pkg.sv
// Shared types and sizing helpers for the FIFOX read-side word merger.
package fifox_rd_merger_pkg;

  typedef enum logic {
    FILL = 1'b0,
    SEND = 1'b1
  } merger_state_t;

  // Idle timer width; a disabled timeout still gets a 1-bit register.
  function automatic int timer_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/fifox_rd_merger_timer.sv
// Idle counter for partial-word flushing; expired marks the last idle cycle.
module fifox_rd_merger_timer
  import fifox_rd_merger_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int TW = timer_width(TIMEOUT);
  localparam logic [TW-1:0] LAST_TICK = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [TW-1:0] r_timer;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_timer <= '0;
    end else if (i_clear) begin
      r_timer <= '0;
    end else if (i_enable && (TIMEOUT != 0)) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  assign o_expired = (TIMEOUT != 0) && (r_timer == LAST_TICK);

endmodule

// File: rtl/fifox_rd_merger.sv
// Packs FWFT FIFO items into wide words with a valid mask; flushes partial
// words after an idle timeout. States: FILL collects items, SEND offers the word.
module fifox_rd_merger
  import fifox_rd_merger_pkg::*;
#(
  parameter int ITEM_WIDTH     = 8,
  parameter int ITEMS_PER_WORD = 4,
  parameter int TIMEOUT        = 16
) (
  input  logic                                 CLK,
  input  logic                                 RESET_N,
  input  logic [ITEM_WIDTH-1:0]                FIFO_DO,
  input  logic                                 FIFO_EMPTY,
  output logic                                 FIFO_RD,
  output logic [ITEMS_PER_WORD*ITEM_WIDTH-1:0] TX_DATA,
  output logic [ITEMS_PER_WORD-1:0]            TX_VLD,
  output logic                                 TX_SRC_RDY,
  input  logic                                 TX_DST_RDY
);

  localparam int CW = $clog2(ITEMS_PER_WORD + 1);
  localparam logic [CW-1:0] LAST_SLOT = CW'(ITEMS_PER_WORD - 1);

  merger_state_t r_state;
  merger_state_t w_next_state;

  logic [ITEMS_PER_WORD-1:0][ITEM_WIDTH-1:0] r_buf;
  logic [ITEMS_PER_WORD-1:0]                 r_vld;
  logic [CW-1:0]                             r_cnt;

  logic w_pop;
  logic w_accept;
  logic w_expired;
  logic w_tmr_clear;
  logic w_tmr_en;
  logic w_src_rdy;

  // In SEND a pop is only allowed on the acceptance edge, landing in slot 0.
  assign w_pop       = ~FIFO_EMPTY & ((r_state == FILL) | TX_DST_RDY) & RESET_N;
  assign w_accept    = (r_state == SEND) & TX_DST_RDY;
  assign w_tmr_clear = w_pop | w_accept | (r_cnt == '0);
  assign w_tmr_en    = (r_state == FILL) & ~w_pop & (r_cnt != '0);

  fifox_rd_merger_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .i_clk     (CLK),
    .i_rst_n   (RESET_N),
    .i_clear   (w_tmr_clear),
    .i_enable  (w_tmr_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= FILL;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      FILL: begin
        if (w_pop && (r_cnt == LAST_SLOT)) begin
          w_next_state = SEND;
        end else if (!w_pop && (r_cnt != '0) && w_expired) begin
          w_next_state = SEND;
        end
      end
      SEND: begin
        if (TX_DST_RDY) begin
          w_next_state = FILL;
        end
      end
      default: w_next_state = FILL;
    endcase
  end

  always_comb begin
    w_src_rdy = (r_state == SEND);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_buf <= '0;
      r_vld <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_buf <= '0;
      r_vld <= '0;
      r_cnt <= '0;
      if (w_pop) begin
        r_buf[0] <= FIFO_DO;
        r_vld[0] <= 1'b1;
        r_cnt    <= CW'(1);
      end
    end else if ((r_state == FILL) && w_pop) begin
      for (int i = 0; i < ITEMS_PER_WORD; i++) begin
        if (r_cnt == CW'(i)) begin
          r_buf[i] <= FIFO_DO;
          r_vld[i] <= 1'b1;
        end
      end
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign FIFO_RD    = w_pop;
  assign TX_DATA    = r_buf;
  assign TX_VLD     = r_vld;
  assign TX_SRC_RDY = w_src_rdy;

endmodule

// File: tb/tb_fifox_rd_merger.sv
// Directed bench for fifox_rd_merger: FWFT FIFO model feeding the merger.
module tb_fifox_rd_merger;

  logic        CLK;
  logic        RESET_N;
  logic [7:0]  FIFO_DO;
  logic        FIFO_EMPTY;
  logic        FIFO_RD;
  logic [31:0] TX_DATA;
  logic [3:0]  TX_VLD;
  logic        TX_SRC_RDY;
  logic        TX_DST_RDY;

  logic [7:0]  do0;
  logic        empty0;
  logic        rd0;
  logic [31:0] data0;
  logic [3:0]  vld0;
  logic        src_rdy0;
  logic        dst_rdy0;

  logic [7:0]  fq[$];
  logic        last_rd;
  int          n_cmp;
  int          n_err;
  int          n;
  int          seen;

  fifox_rd_merger #(.ITEM_WIDTH(8), .ITEMS_PER_WORD(4), .TIMEOUT(16)) u_dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .FIFO_DO    (FIFO_DO),
    .FIFO_EMPTY (FIFO_EMPTY),
    .FIFO_RD    (FIFO_RD),
    .TX_DATA    (TX_DATA),
    .TX_VLD     (TX_VLD),
    .TX_SRC_RDY (TX_SRC_RDY),
    .TX_DST_RDY (TX_DST_RDY)
  );

  fifox_rd_merger #(.ITEM_WIDTH(8), .ITEMS_PER_WORD(4), .TIMEOUT(0)) u_dut0 (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .FIFO_DO    (do0),
    .FIFO_EMPTY (empty0),
    .FIFO_RD    (rd0),
    .TX_DATA    (data0),
    .TX_VLD     (vld0),
    .TX_SRC_RDY (src_rdy0),
    .TX_DST_RDY (dst_rdy0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    FIFO_EMPTY = (fq.size() == 0);
    FIFO_DO    = (fq.size() == 0) ? 8'h00 : fq[0];
  endtask

  // One clock: present head, sample the pop strobe, retire the item on the edge.
  task automatic tick();
    drive();
    #1;
    last_rd = FIFO_RD;
    @(posedge CLK);
    if (last_rd && fq.size() > 0) void'(fq.pop_front());
    @(negedge CLK);
    drive();
  endtask

  task automatic wait_src(output int cnt);
    cnt = 0;
    while (!TX_SRC_RDY && cnt < 40) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; last_rd = 1'b0;
    RESET_N = 1'b0; TX_DST_RDY = 1'b0;
    empty0 = 1'b1; do0 = 8'h00; dst_rdy0 = 1'b1;
    fq.push_back(8'h77);
    drive();
    @(negedge CLK); @(negedge CLK);
    #1;
    chk("rst_src_rdy", TX_SRC_RDY, 0);
    chk("rst_data", TX_DATA, 0);
    chk("rst_vld", TX_VLD, 0);
    chk("rst_fifo_rd", FIFO_RD, 0);
    fq.delete();
    @(negedge CLK);
    RESET_N = 1'b1;
    tick();
    chk("idle_src_rdy", TX_SRC_RDY, 0);

    // Full word
    TX_DST_RDY = 1'b1;
    fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33); fq.push_back(8'h44);
    tick(); tick(); tick();
    chk("full_pre_src", TX_SRC_RDY, 0);
    tick();
    chk("full_src", TX_SRC_RDY, 1);
    chk("full_data", TX_DATA, 32'h44332211);
    chk("full_vld", TX_VLD, 4'hF);
    tick();
    chk("full_acc_src", TX_SRC_RDY, 0);
    chk("full_acc_vld", TX_VLD, 0);
    chk("full_acc_data", TX_DATA, 0);

    // Timeout flush with downstream stalled
    TX_DST_RDY = 1'b0;
    fq.push_back(8'hA1); fq.push_back(8'hA2);
    tick(); tick();
    chk("to_partial_vld", TX_VLD, 4'h3);
    wait_src(n);
    chk("to_latency", n, 16);
    chk("to_data", TX_DATA, 32'h0000A2A1);
    chk("to_vld", TX_VLD, 4'h3);

    // Backpressure with a full FIFO
    fq.push_back(8'hB0); fq.push_back(8'hB1); fq.push_back(8'hB2); fq.push_back(8'hB3);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_fifo_rd", last_rd, 0);
      chk("bp_data", TX_DATA, 32'h0000A2A1);
      chk("bp_src", TX_SRC_RDY, 1);
    end
    chk("bp_fifo_level", fq.size(), 4);
    TX_DST_RDY = 1'b1;
    drive();
    #1;
    chk("bp_release_rd", FIFO_RD, 1);
    tick();
    chk("bp_acc_src", TX_SRC_RDY, 0);
    chk("bp_acc_vld", TX_VLD, 4'h1);
    chk("bp_acc_data", TX_DATA, 32'h000000B0);
    tick(); tick(); tick();
    chk("bp_word_src", TX_SRC_RDY, 1);
    chk("bp_word_data", TX_DATA, 32'hB3B2B1B0);
    chk("bp_word_vld", TX_VLD, 4'hF);
    tick();
    chk("bp_done_src", TX_SRC_RDY, 0);

    // Streaming 64 items
    for (int i = 0; i < 64; i++) fq.push_back(8'(i));
    seen = 0;
    for (int k = 0; k < 64; k++) begin
      tick();
      chk("stream_src", TX_SRC_RDY, (k % 4 == 3) ? 1 : 0);
      if (k % 4 == 3) begin
        chk("stream_data", TX_DATA,
            {8'(seen*4+3), 8'(seen*4+2), 8'(seen*4+1), 8'(seen*4)});
        chk("stream_vld", TX_VLD, 4'hF);
        seen++;
      end
    end
    chk("stream_words", seen, 16);
    chk("stream_drained", fq.size(), 0);
    tick();
    chk("stream_done_src", TX_SRC_RDY, 0);

    // Pop on the expiry cycle restarts the timer
    fq.push_back(8'hC1);
    tick();
    repeat (15) tick();
    chk("race_pre_src", TX_SRC_RDY, 0);
    fq.push_back(8'hC2);
    tick();
    chk("race_pop_src", TX_SRC_RDY, 0);
    wait_src(n);
    chk("race_latency", n, 16);
    chk("race_data", TX_DATA, 32'h0000C2C1);
    chk("race_vld", TX_VLD, 4'h3);
    tick();
    chk("race_acc_src", TX_SRC_RDY, 0);

    // Expiry-cycle pop that completes the word
    fq.push_back(8'hE1); fq.push_back(8'hE2); fq.push_back(8'hE3);
    tick(); tick(); tick();
    repeat (15) tick();
    chk("racefull_pre_src", TX_SRC_RDY, 0);
    fq.push_back(8'hE4);
    tick();
    chk("racefull_src", TX_SRC_RDY, 1);
    chk("racefull_data", TX_DATA, 32'hE4E3E2E1);
    chk("racefull_vld", TX_VLD, 4'hF);
    tick();

    // TIMEOUT=0 never flushes
    empty0 = 1'b0; do0 = 8'h5A;
    #1;
    chk("t0_rd", rd0, 1);
    @(posedge CLK);
    @(negedge CLK);
    empty0 = 1'b1;
    seen = 0;
    repeat (1000) begin
      @(negedge CLK);
      if (src_rdy0) seen = 1;
    end
    chk("t0_no_output", seen, 0);
    chk("t0_vld", vld0, 4'h1);
    chk("t0_data", data0, 32'h0000005A);

    // Reset mid-word
    fq.push_back(8'hD1); fq.push_back(8'hD2);
    tick(); tick();
    chk("rstmid_vld_pre", TX_VLD, 4'h3);
    fq.push_back(8'hD3); fq.push_back(8'hD4); fq.push_back(8'hD5); fq.push_back(8'hD6);
    drive();
    RESET_N = 1'b0;
    #1;
    chk("rstmid_src", TX_SRC_RDY, 0);
    chk("rstmid_data", TX_DATA, 0);
    chk("rstmid_vld", TX_VLD, 0);
    chk("rstmid_rd", FIFO_RD, 0);
    @(negedge CLK); @(negedge CLK);
    chk("rstmid_level", fq.size(), 4);
    RESET_N = 1'b1;
    tick(); tick(); tick();
    chk("rstmid_pre_src", TX_SRC_RDY, 0);
    tick();
    chk("rstmid_word_src", TX_SRC_RDY, 1);
    chk("rstmid_word_data", TX_DATA, 32'hD6D5D4D3);
    chk("rstmid_word_vld", TX_VLD, 4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
